input_array_stream: RTL and testbench



---
 rtl/input_array_stream_if.sv | 31 +++
 rtl/input_array_stream.sv | 164 ++++++++++++++++
 tb/tb_input_array_stream.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/input_array_stream_if.sv
// Bus bundle for input_array_stream: entry controls, switch/button inputs,
// packed array output and the valid/ready handoff to the sorter stage.
interface input_array_stream_if #(
  parameter int unsigned SW_W   = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ELEM_W = 5,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
);
  logic                      en;
  logic [SW_W-1:0]           switch;
  logic [2:0]                press;
  logic [CNT_W-1:0]          target_count;
  logic [DEPTH*ELEM_W-1:0]   array_out;
  logic [CNT_W-1:0]          count;
  logic                      out_valid;
  logic                      out_ready;
  logic                      over;
  logic                      err;

  // Upstream / downstream side driving the block
  modport master (
    output en, switch, press, target_count, out_ready,
    input  array_out, count, out_valid, over, err
  );

  // The entry block itself
  modport slave (
    input  en, switch, press, target_count, out_ready,
    output array_out, count, out_valid, over, err
  );
endinterface

// File: rtl/input_array_stream.sv
// One-hot switch array entry with error/undo/clear and valid/ready handoff.
// Optional INPUT_ARRAY_DUP_CHECK_EN rejects values already present in filled slots.
module input_array_stream #(
  parameter int unsigned SW_W   = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ELEM_W = 5,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input logic                 clk,
  input logic                 rst_n,
  input_array_stream_if.slave bus
);

  localparam logic [ELEM_W-1:0] EMPTY = '1;
  localparam logic [2:0] P_RLS = 3'b001;
  localparam logic [2:0] P_CON = 3'b010;
  localparam logic [2:0] P_DEL = 3'b011;

  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_DONE, S_HELD} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  tgt_q, tgt_d;
  logic [ELEM_W-1:0] slots_q [DEPTH];
  logic [ELEM_W-1:0] slots_d [DEPTH];
  logic              valid_q, valid_d;
  logic              over_q, over_d;
  logic              err_q, err_d;

  logic              is_con, is_del, is_rls, room;
  logic              one_hot, dup;
  logic [ELEM_W-1:0] sw_idx;

  assign is_con = (bus.press == P_CON);
  assign is_del = (bus.press == P_DEL);
  assign is_rls = (bus.press == P_RLS);
  assign room   = (count_q < tgt_q);

  // Switch decode: one-hot test, bit index and duplicate lookup
  always_comb begin
    sw_idx  = '0;
    for (int i = 0; i < SW_W; i++) begin
      if (bus.switch[i]) sw_idx = ELEM_W'(i);
    end
    one_hot = (bus.switch != '0) && ((bus.switch & (bus.switch - SW_W'(1))) == '0);
    dup     = 1'b0;
`ifdef INPUT_ARRAY_DUP_CHECK_EN
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count_q) && (slots_q[i] == sw_idx)) dup = 1'b1;
    end
`endif
  end

  // State register plus registered datapath/outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      tgt_q   <= '0;
      valid_q <= 1'b0;
      over_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) slots_q[i] <= EMPTY;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tgt_q   <= tgt_d;
      valid_q <= valid_d;
      over_q  <= over_d;
      err_q   <= err_d;
      for (int i = 0; i < DEPTH; i++) slots_q[i] <= slots_d[i];
    end
  end

  // Next-state logic; en low always returns to IDLE
  always_comb begin
    state_d = state_q;
    if (!bus.en) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_ENTRY;
        S_ENTRY: if (is_con && !room) state_d = S_DONE;
        S_DONE: begin
          if (bus.out_ready)        state_d = S_HELD;
          else if (is_del || is_rls) state_d = S_ENTRY;
        end
        S_HELD:  state_d = S_HELD;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Next values of slots, count, target and output flags
  always_comb begin
    count_d = count_q;
    tgt_d   = tgt_q;
    valid_d = valid_q;
    over_d  = 1'b0;
    err_d   = 1'b0;
    for (int i = 0; i < DEPTH; i++) slots_d[i] = slots_q[i];

    if (!bus.en) begin
      count_d = '0;
      tgt_d   = '0;
      valid_d = 1'b0;
      for (int i = 0; i < DEPTH; i++) slots_d[i] = EMPTY;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          tgt_d = (bus.target_count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : bus.target_count;
        end
        S_ENTRY: begin
          if (is_con) begin
            if (!room) begin
              valid_d = 1'b1;
            end else if (one_hot && !dup) begin
              for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == count_q) slots_d[i] = sw_idx;
              end
              count_d = count_q + CNT_W'(1);
            end else begin
              err_d = 1'b1;
            end
          end else if (is_del) begin
            if (count_q != '0) begin
              for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == count_q - CNT_W'(1)) slots_d[i] = EMPTY;
              end
              count_d = count_q - CNT_W'(1);
            end
          end else if (is_rls) begin
            count_d = '0;
            for (int i = 0; i < DEPTH; i++) slots_d[i] = EMPTY;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            over_d  = 1'b1;
            valid_d = 1'b0;
          end else if (is_del) begin
            valid_d = 1'b0;
          end else if (is_rls) begin
            valid_d = 1'b0;
            count_d = '0;
            for (int i = 0; i < DEPTH; i++) slots_d[i] = EMPTY;
          end
        end
        default: ;
      endcase
    end
  end

  // Slot 0 lands in the most significant field
  for (genvar g = 0; g < DEPTH; g++) begin : g_pack
    assign bus.array_out[(DEPTH-1-g)*ELEM_W +: ELEM_W] = slots_q[g];
  end

  assign bus.count     = count_q;
  assign bus.out_valid = valid_q;
  assign bus.over      = over_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_input_array_stream.sv
// Self-checking bench for input_array_stream: directed scenarios plus random
// stimulus against a queue-based reference model.
module tb_input_array_stream;

  localparam int unsigned SW_W   = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ELEM_W = 5;
  localparam int unsigned CNT_W  = 3;

  localparam logic [2:0] NXT = 3'b000, RLS = 3'b001, CON = 3'b010,
                         DEL = 3'b011, RIS = 3'b100, NON = 3'b111;
  localparam int M_IDLE = 0, M_ENTRY = 1, M_DONE = 2, M_HELD = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  input_array_stream_if #(.SW_W(SW_W), .DEPTH(DEPTH), .ELEM_W(ELEM_W), .CNT_W(CNT_W)) bus ();

  input_array_stream #(.SW_W(SW_W), .DEPTH(DEPTH), .ELEM_W(ELEM_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: mode, list of entered values, clamped target, flags
  int m_mode;
  int m_q[$];
  int m_tgt;
  bit m_valid, m_over, m_err;

  function automatic logic [19:0] exp_arr();
    logic [19:0] r;
    for (int i = 0; i < 4; i++)
      r[(3-i)*5 +: 5] = (i < m_q.size()) ? 5'(m_q[i]) : 5'h1F;
    return r;
  endfunction

  function automatic void model_step(bit e, logic [7:0] sw, logic [2:0] pr, logic [2:0] tc, bit rdy);
    int  v;
    bit  ok, dupv;
    m_over = 0;
    m_err  = 0;
    if (!e) begin
      m_mode = M_IDLE; m_q.delete(); m_valid = 0; m_tgt = 0;
    end else if (m_mode == M_IDLE) begin
      m_tgt  = (int'(tc) > 4) ? 4 : int'(tc);
      m_mode = M_ENTRY;
    end else if (m_mode == M_ENTRY) begin
      if (pr == CON) begin
        if (m_q.size() >= m_tgt) begin
          m_mode = M_DONE; m_valid = 1;
        end else begin
          ok   = ($countones(sw) == 1);
          v    = $clog2(sw);
          dupv = 0;
`ifdef INPUT_ARRAY_DUP_CHECK_EN
          foreach (m_q[j]) if (m_q[j] == v) dupv = 1;
`endif
          if (ok && !dupv) m_q.push_back(v);
          else m_err = 1;
        end
      end else if (pr == DEL) begin
        if (m_q.size() > 0) void'(m_q.pop_back());
      end else if (pr == RLS) begin
        m_q.delete();
      end
    end else if (m_mode == M_DONE) begin
      if (rdy) begin
        m_over = 1; m_valid = 0; m_mode = M_HELD;
      end else if (pr == DEL) begin
        m_valid = 0; m_mode = M_ENTRY;
      end else if (pr == RLS) begin
        m_valid = 0; m_mode = M_ENTRY; m_q.delete();
      end
    end
  endfunction

  task automatic apply(bit e, logic [7:0] sw, logic [2:0] pr, logic [2:0] tc, bit rdy);
    bus.en = e; bus.switch = sw; bus.press = pr; bus.target_count = tc; bus.out_ready = rdy;
    model_step(e, sw, pr, tc, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.en = 0; bus.switch = '0; bus.press = NON; bus.target_count = '0; bus.out_ready = 0;
    rst_n = 0;
    m_mode = M_IDLE; m_q.delete(); m_tgt = 0; m_valid = 0; m_over = 0; m_err = 0;
    repeat (2) @(negedge clk);
    checks++; if (bus.array_out !== 20'hFFFFF) begin failures++; $display("FAIL reset_array got=%h exp=fffff", bus.array_out); end
    checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if ({bus.out_valid, bus.over, bus.err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {bus.out_valid, bus.over, bus.err}); end
    rst_n = 1;
    apply(0, 8'h00, NON, 3'd0, 0);
  endtask

  task automatic test_fill_accept();
    logic [7:0] sws [5] = '{8'h02, 8'h80, 8'h01, 8'h10, 8'h00};
    apply(1, 8'h00, NON, 3'd4, 0);
    for (int k = 0; k < 5; k++) begin
      apply(1, sws[k], CON, 3'd4, 0);
      checks++; if (bus.count !== 3'(m_q.size())) begin failures++; $display("FAIL fill_count step=%0d got=%0d exp=%0d", k, bus.count, m_q.size()); end
    end
    checks++; if (bus.array_out !== 20'h09C04) begin failures++; $display("FAIL fill_array got=%h exp=09c04", bus.array_out); end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL fill_valid got=%b exp=1", bus.out_valid); end
    apply(1, 8'h00, NON, 3'd4, 1);
    checks++; if ({bus.over, bus.out_valid} !== 2'b10) begin failures++; $display("FAIL accept_over got=%b exp=10", {bus.over, bus.out_valid}); end
    apply(1, 8'h01, DEL, 3'd4, 0);
    checks++; if ({bus.over, bus.count, bus.array_out} !== {1'b0, 3'd4, 20'h09C04}) begin failures++; $display("FAIL held_frozen got=%b/%0d/%h exp=0/4/09c04", bus.over, bus.count, bus.array_out); end
  endtask

  task automatic test_err();
    apply(0, 8'h00, NON, 3'd3, 0);
    apply(1, 8'h00, NON, 3'd3, 0);
    apply(1, 8'h04, CON, 3'd3, 0);
    apply(1, 8'h03, CON, 3'd3, 0);
    checks++; if ({bus.err, bus.count} !== {1'b1, 3'd1}) begin failures++; $display("FAIL err_pulse got=%b/%0d exp=1/1", bus.err, bus.count); end
    checks++; if (bus.array_out !== 20'h17FFF) begin failures++; $display("FAIL err_array got=%h exp=17fff", bus.array_out); end
    apply(1, 8'h00, CON, 3'd3, 0);
    checks++; if ({bus.err, bus.count} !== {1'b1, 3'd1}) begin failures++; $display("FAIL err_zero got=%b/%0d exp=1/1", bus.err, bus.count); end
    apply(1, 8'h00, NON, 3'd3, 0);
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", bus.err); end
  endtask

  task automatic test_delete();
    logic [2:0] exp_cnt [3] = '{3'd1, 3'd0, 3'd0};
    apply(0, 8'h00, NON, 3'd4, 0);
    apply(1, 8'h00, NON, 3'd4, 0);
    apply(1, 8'h20, CON, 3'd4, 0);
    apply(1, 8'h40, CON, 3'd4, 0);
    for (int k = 0; k < 3; k++) begin
      apply(1, 8'h00, DEL, 3'd4, 0);
      checks++; if ({bus.count, bus.err} !== {exp_cnt[k], 1'b0}) begin failures++; $display("FAIL del_count step=%0d got=%0d/%b exp=%0d/0", k, bus.count, bus.err, exp_cnt[k]); end
    end
    checks++; if (bus.array_out !== 20'hFFFFF) begin failures++; $display("FAIL del_array got=%h exp=fffff", bus.array_out); end
  endtask

  task automatic test_undo();
    apply(0, 8'h00, NON, 3'd2, 0);
    apply(1, 8'h00, NON, 3'd2, 0);
    apply(1, 8'h01, CON, 3'd2, 0);
    apply(1, 8'h02, CON, 3'd2, 0);
    apply(1, 8'h00, CON, 3'd2, 0);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL undo_done got=%b exp=1", bus.out_valid); end
    apply(1, 8'h00, DEL, 3'd2, 0);
    checks++; if ({bus.out_valid, bus.count} !== {1'b0, 3'd2}) begin failures++; $display("FAIL undo_first got=%b/%0d exp=0/2", bus.out_valid, bus.count); end
    apply(1, 8'h00, DEL, 3'd2, 0);
    checks++; if ({bus.count, bus.array_out} !== {3'd1, 20'h07FFF}) begin failures++; $display("FAIL undo_second got=%0d/%h exp=1/07fff", bus.count, bus.array_out); end
  endtask

  task automatic test_clamp();
    apply(0, 8'h00, NON, 3'd7, 0);
    apply(1, 8'h00, NON, 3'd7, 0);
    for (int k = 0; k < 5; k++) apply(1, 8'(1 << k), CON, 3'd7, 0);
    checks++; if ({bus.count, bus.out_valid, bus.array_out} !== {3'd4, 1'b1, 20'h00443}) begin failures++; $display("FAIL clamp got=%0d/%b/%h exp=4/1/00443", bus.count, bus.out_valid, bus.array_out); end
    apply(0, 8'h00, NON, 3'd4, 0);
    apply(1, 8'h00, NON, 3'd4, 0);
    apply(1, 8'h01, CON, 3'd4, 0);
    apply(1, 8'h02, CON, 3'd4, 0);
    apply(0, 8'h04, CON, 3'd4, 0);
    checks++; if ({bus.count, bus.array_out} !== {3'd0, 20'hFFFFF}) begin failures++; $display("FAIL en_drop got=%0d/%h exp=0/fffff", bus.count, bus.array_out); end
  endtask

  task automatic test_dup();
    apply(0, 8'h00, NON, 3'd4, 0);
    apply(1, 8'h00, NON, 3'd4, 0);
    apply(1, 8'h08, CON, 3'd4, 0);
    apply(1, 8'h08, CON, 3'd4, 0);
`ifdef INPUT_ARRAY_DUP_CHECK_EN
    checks++; if ({bus.err, bus.count, bus.array_out} !== {1'b1, 3'd1, 20'h1FFFF}) begin failures++; $display("FAIL dup_reject got=%b/%0d/%h exp=1/1/1ffff", bus.err, bus.count, bus.array_out); end
`else
    checks++; if ({bus.err, bus.count, bus.array_out} !== {1'b0, 3'd2, 20'h18FFF}) begin failures++; $display("FAIL dup_accept got=%b/%0d/%h exp=0/2/18fff", bus.err, bus.count, bus.array_out); end
`endif
  endtask

  task automatic test_back_to_back();
    apply(0, 8'h00, NON, 3'd1, 0);
    apply(1, 8'h00, NON, 3'd1, 0);
    apply(1, 8'h40, CON, 3'd1, 0);
    apply(1, 8'h00, CON, 3'd1, 0);
    apply(1, 8'h00, DEL, 3'd1, 1);
    checks++; if ({bus.over, bus.out_valid, bus.count} !== {1'b1, 1'b0, 3'd1}) begin failures++; $display("FAIL ready_wins got=%b/%b/%0d exp=1/0/1", bus.over, bus.out_valid, bus.count); end
    apply(1, 8'h00, RLS, 3'd1, 0);
    checks++; if ({bus.over, bus.count, bus.array_out} !== {1'b0, 3'd1, 20'h37FFF}) begin failures++; $display("FAIL held_rls got=%b/%0d/%h exp=0/1/37fff", bus.over, bus.count, bus.array_out); end
  endtask

  task automatic test_random();
    logic [2:0] codes [6] = '{NXT, RLS, CON, DEL, RIS, NON};
    logic [7:0] sw;
    logic [2:0] pr;
    logic [2:0] tc;
    bit e, rdy;
    int bad;
    bad = 0;
    tc = 3'($urandom_range(0, 7));
    for (int k = 0; k < 600; k++) begin
      e   = ($urandom_range(0, 39) != 0);
      if (!e) tc = 3'($urandom_range(0, 7));
      sw  = ($urandom_range(0, 3) != 0) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      pr  = ($urandom_range(0, 1) != 0) ? NON : codes[$urandom_range(0, 5)];
      rdy = ($urandom_range(0, 3) == 0);
      apply(e, sw, pr, tc, rdy);
      if ({bus.array_out, bus.count, bus.out_valid, bus.over, bus.err} !==
          {exp_arr(), 3'(m_q.size()), m_valid, m_over, m_err}) begin
        bad++;
        if (bad <= 5)
          $display("FAIL random cyc=%0d got=%h/%0d/%b%b%b exp=%h/%0d/%b%b%b", k,
                   bus.array_out, bus.count, bus.out_valid, bus.over, bus.err,
                   exp_arr(), m_q.size(), m_valid, m_over, m_err);
      end
      if (bus.over && bus.err) begin
        bad++;
        $display("FAIL over_err_overlap cyc=%0d got=11 exp=not both", k);
      end
    end
    checks++;
    if (bad != 0) failures++;
  endtask

  initial begin
    test_reset();
    test_fill_accept();
    test_err();
    test_delete();
    test_undo();
    test_clamp();
    test_dup();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
